mux8_rr_arbiter: RTL and testbench
==================================

Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 multiplexer (`mux_8x1`: D[7:0], S[2:0], Y) among 8 requesters.
- Drives the mux select and a one-hot grant, and enforces a maximum hold time per grant.
- Presents the selected data bit as a gated output.
- Sits between 8 single-bit sources and one shared serial consumer.

Parameters:
- MAX_HOLD, default 4: maximum consecutive cycles one requester may hold a grant. Legal range 1..255.
- CNT_W, default 8: width of the hold counter. Must hold MAX_HOLD-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  8  request per channel; req[i] is held high while channel i wants the mux.
- D    in  8  data bits, D[i] belongs to channel i; passed to the internal mux_8x1.
- S    out 3  registered select driven to the mux_8x1 S input. Equals the granted channel index.
- gnt  out 8  registered one-hot grant; all zero when idle.
- busy out 1  registered; high while a grant is active.
- Y    out 1  equals D[S] when busy=1, otherwise 0. Combinational from the internal mux_8x1 output.

Behaviour:
- Reset (rst=1 at a rising edge): gnt=0, S=0, busy=0, ptr=0, hold_cnt=0, state=IDLE. Reset overrides everything and may abort an active grant mid-hold. Y=0 one cycle after reset is sampled.
- State machine has two states, IDLE and GRANT.
- Internal pointer ptr[2:0]: the highest-priority channel for the next arbitration.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w = the first i with req[i]=1, scanning ptr, ptr+1, ... ptr+7 modulo 8.
  - At the edge: S<=w, gnt<=1<<w, busy<=1, hold_cnt<=0, state<=GRANT.
  - Latency is 1 cycle: a request seen at edge n gives gnt visible after edge n.
- GRANT, on each edge:
  - Release condition: req[S]==0, or hold_cnt==MAX_HOLD-1.
  - If the release condition is true:
    - gnt<=0, busy<=0, ptr<=S+1 (mod 8, so 7 wraps to 0), state<=IDLE.
    - S keeps its last value.
  - Otherwise hold_cnt<=hold_cnt+1.
- Grant length: a continuously requesting channel holds gnt for exactly MAX_HOLD cycles. It is then followed by exactly one idle cycle (busy=0), then re-arbitration.
- Fairness: after channel k is released, every other requesting channel is served before k again. Worst-case wait is 7*(MAX_HOLD+1) cycles.
- Simultaneous events:
  - A requester dropping req on the same edge the hold limit expires counts as a single release; ptr advances once.
  - New requests arriving during GRANT are not considered until the IDLE cycle.
  - Changes to req[j] for j≠S during GRANT are ignored.
- MAX_HOLD=1: every grant lasts 1 cycle, alternating with 1 idle cycle.
- gnt is always one-hot or zero. gnt[S]==busy at all times.
- No combinational path from req to gnt, S or busy.

Test Plan:
- Reset check: assert rst for 2 cycles with req=8'hFF → gnt=0, S=0, busy=0, Y=0. After release, the first grant goes to channel 0 (gnt=8'h01, S=0) one cycle later.
- Round-robin order with continuous req=8'hFF, MAX_HOLD=4:
  - gnt sequence is 01,02,04,...,80, then 01 again.
  - Each grant lasts 4 cycles, separated by 1 cycle of busy=0.
  - ptr wraps from 7 to 0.
- Early release: req=8'h10 for 2 cycles then 0 → gnt=8'h10 for exactly 2 cycles, then busy=0. The next single request req=8'h08 is granted (pointer was 5, scan wraps to 3).
- Data path: grant channel 5, drive D=8'h20 then D=8'hDF → Y=1 then Y=0 while busy=1. Y=0 whenever busy=0, regardless of D.
- Ignore-during-grant: channel 2 granted, raise req[0] mid-grant → gnt stays 8'h04 until release. Channel 0 is granted only after the idle cycle.
- Reset mid-grant: assert rst at the 2nd cycle of a grant to channel 6 → gnt=0, busy=0, ptr=0 next cycle. With req=8'h41, the next grant is channel 0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 single-bit requesters.
// Grants are registered, one-hot, and capped at MAX_HOLD consecutive cycles.
// Each grant is followed by one idle cycle in which the next winner is chosen.

// Plain 8:1 bit multiplexer shared by all channels.
module mux_8x1 (
  input  logic [7:0] D,
  input  logic [2:0] S,
  output logic       Y
);
  assign Y = D[S];
endmodule

module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] D,
  output logic [2:0] S,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       Y
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Last count value before a continuously requesting owner must let go.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_ptr;
  logic [2:0]       w_ptr_nxt;
  logic [2:0]       r_sel;
  logic [2:0]       w_sel_nxt;
  logic [7:0]       r_gnt;
  logic [7:0]       w_gnt_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] w_hold_cnt_nxt;

  logic [15:0]      w_req_dbl;
  logic [7:0]       w_req_rot;
  logic [2:0]       w_off;
  logic [2:0]       w_win;
  logic             w_release;
  logic             w_mux_y;

  // Winner search: rotate req so the pointer channel lands at bit 0, then
  // take the lowest set bit; scanning downwards lets the lowest offset win.
  always_comb begin
    w_req_dbl = {req, req};
    w_req_rot = w_req_dbl[r_ptr +: 8];
    w_off     = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_off = w_req_rot[k] ? 3'(k) : w_off;
    end
    w_win = r_ptr + w_off;
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_sel_nxt      = r_sel;
    w_gnt_nxt      = r_gnt;
    w_busy_nxt     = r_busy;
    w_hold_cnt_nxt = r_hold_cnt;
    // A dropped request and an expired hold limit collapse into one release.
    w_release      = (req[r_sel] == 1'b0) || (r_hold_cnt == HOLD_LAST);
    case (r_state)
      IDLE: begin
        if (req != 8'h00) begin
          w_sel_nxt      = w_win;
          w_gnt_nxt      = 8'h01 << w_win;
          w_busy_nxt     = 1'b1;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = GRANT;
        end else begin
          w_state_nxt    = IDLE;
        end
      end
      GRANT: begin
        if (w_release) begin
          // S keeps its value so the mux stays stable through the idle cycle.
          w_gnt_nxt   = 8'h00;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_sel + 3'd1;
          w_state_nxt = IDLE;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_gnt_nxt   = 8'h00;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset that can abort a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 3'd0;
      r_sel      <= 3'd0;
      r_gnt      <= 8'h00;
      r_busy     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt      <= w_gnt_nxt;
      r_busy     <= w_busy_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  mux_8x1 u_mux (
    .D (D),
    .S (r_sel),
    .Y (w_mux_y)
  );

  assign S    = r_sel;
  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign Y    = w_mux_y & r_busy;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: a cycle model pushes expected outputs
// when inputs are driven; they are popped and compared after the clock edge.
module tb_mux8_rr_arbiter;

  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       y;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] D;
  logic [2:0] S;
  logic [7:0] gnt;
  logic       busy;
  logic       Y;

  int n_tests;
  int n_fail;

  exp_t sb_q[$];

  // Reference model state
  logic [2:0] m_ptr;
  logic [2:0] m_s;
  logic [7:0] m_gnt;
  logic       m_busy;
  int         m_cnt;

  mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .D    (D),
    .S    (S),
    .gnt  (gnt),
    .busy (busy),
    .Y    (Y)
  );

  // Free-running clock, 10 time units period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge and queue the outputs it predicts.
  task automatic model_edge(input logic r, input logic [7:0] rq, input logic [7:0] d);
    exp_t       e;
    logic       found;
    logic [2:0] idx;
    if (r) begin
      m_ptr = 3'd0; m_s = 3'd0; m_gnt = 8'h00; m_busy = 1'b0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        idx = 3'((int'(m_ptr) + k) % 8);
        if (!found && rq[idx]) begin
          found = 1'b1;
          m_s   = idx;
        end
      end
      if (found) begin
        m_gnt  = 8'h01 << m_s;
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      if (!rq[m_s] || m_cnt == MAX_HOLD - 1) begin
        m_gnt  = 8'h00;
        m_busy = 1'b0;
        m_ptr  = m_s + 3'd1;
      end else begin
        m_cnt++;
      end
    end
    e.gnt  = m_gnt;
    e.s    = m_s;
    e.busy = m_busy;
    e.y    = m_busy & d[m_s];
    sb_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, check #1 after the rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    D   = d;
    model_edge(r, rq, d);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk("sb_gnt",  32'(gnt),  32'(e.gnt));
      chk("sb_s",    32'(S),    32'(e.s));
      chk("sb_busy", 32'(busy), 32'(e.busy));
      chk("sb_y",    32'(Y),    32'(e.y));
    end
    chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
    chk("inv_gnt_s",  32'(gnt[S]),        32'(busy));
  endtask

  initial begin
    logic [7:0] rq;
    logic       r;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = 8'hFF;
    D   = 8'h00;
    m_ptr = 3'd0; m_s = 3'd0; m_gnt = 8'h00; m_busy = 1'b0; m_cnt = 0;

    // Reset held two cycles with every channel requesting
    step(1'b1, 8'hFF, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    chk("rst_gnt",  32'(gnt),  32'h00);
    chk("rst_s",    32'(S),    32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y",    32'(Y),    32'd0);

    // Continuous requests: 4-cycle grants, 1 idle cycle, 0..7 then wrap to 0
    for (int c = 0; c < 45; c++) begin
      step(1'b0, 8'hFF, 8'h00);
      chk("rr_gnt",  32'(gnt),  (c % 5 < 4) ? (32'd1 << ((c / 5) % 8)) : 32'd0);
      chk("rr_busy", 32'(busy), (c % 5 < 4) ? 32'd1 : 32'd0);
      if (c % 5 < 4) begin
        chk("rr_s", 32'(S), 32'((c / 5) % 8));
      end else begin
        chk("rr_idle_y", 32'(Y), 32'd0);
      end
    end

    // Early release of channel 4 after 2 cycles, then pointer 5 wraps to 3
    step(1'b0, 8'h10, 8'h00); chk("er_g1", 32'(gnt), 32'h10);
    step(1'b0, 8'h10, 8'h00); chk("er_g2", 32'(gnt), 32'h10);
    step(1'b0, 8'h00, 8'h00); chk("er_rel", 32'(busy), 32'd0);
    step(1'b0, 8'h08, 8'h00); chk("er_wrap", 32'(gnt), 32'h08);
    step(1'b0, 8'h00, 8'h00); chk("er_rel3", 32'(gnt), 32'h00);

    // Data path through channel 5
    step(1'b0, 8'h20, 8'h20); chk("dp_s", 32'(S), 32'd5); chk("dp_y1", 32'(Y), 32'd1);
    step(1'b0, 8'h20, 8'hDF); chk("dp_y0", 32'(Y), 32'd0); chk("dp_busy", 32'(busy), 32'd1);
    step(1'b0, 8'h00, 8'hFF); chk("dp_idle_y", 32'(Y), 32'd0);

    // New request on channel 0 is ignored until channel 2 releases
    step(1'b0, 8'h04, 8'h00); chk("ig_g0", 32'(gnt), 32'h04);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 8'h05, 8'h00); chk("ig_hold", 32'(gnt), 32'h04);
    end
    step(1'b0, 8'h05, 8'h00); chk("ig_idle", 32'(busy), 32'd0);
    step(1'b0, 8'h05, 8'h00); chk("ig_ch0", 32'(gnt), 32'h01);
    step(1'b0, 8'h00, 8'h00);

    // Reset aborts channel 6 mid-grant; pointer returns to 0
    step(1'b0, 8'h40, 8'h00); chk("rm_g6", 32'(gnt), 32'h40);
    step(1'b1, 8'h41, 8'h00); chk("rm_gnt", 32'(gnt), 32'h00); chk("rm_busy", 32'(busy), 32'd0);
    step(1'b0, 8'h41, 8'h00); chk("rm_ch0", 32'(gnt), 32'h01);

    // Random traffic with sticky requests and occasional reset
    rq = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      r = ($urandom_range(0, 49) == 0);
      step(r, rq, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
